frame_buffer: RTL and testbench
===============================

// Module: frame_buffer
// PURPOSE
//  Banked simple-dual-port frame store: one write port, one read port, both on clk_i.
//  The flat pixel address space is split across NUMBER_BRAM block-RAM banks of DEPTH_SIZE words each.
//  Sits between a pixel producer (camera/renderer, write side) and a display/scan-out engine (read side).
// PARAMETERS
//  ADDR_WIDTH   32    width of the flat write/read addresses
//  DATA_WIDTH   16    pixel word width (e.g. RGB565)
//  NUMBER_BRAM  10    number of banks; need not be a power of 2
//  DEPTH_SIZE   1024  words per bank; total capacity = NUMBER_BRAM*DEPTH_SIZE words
// PORTS
//  clk_i      in   1           single clock; all logic on its rising edge
//  resetn_i   in   1           asynchronous reset, active-HIGH (1 = reset) despite the name
//  wr0_i      in   1           write enable for the current cycle
//  addr_wr0   in   ADDR_WIDTH  flat write address
//  Data_in0   in   DATA_WIDTH  write data
//  addr_rd0   in   ADDR_WIDTH  flat read address
//  Data_out0  out  DATA_WIDTH  registered read data
// BEHAVIOUR
//  - Address decode: bank = addr / DEPTH_SIZE, offset = addr % DEPTH_SIZE.
//    Use shift/mask when DEPTH_SIZE is a power of 2; otherwise use a constant divide.
//  - Write: on a rising clk_i edge with wr0_i=1 and resetn_i=0, mem[bank][offset] <= Data_in0.
//    Only the addressed bank is enabled. No handshake; every cycle can carry a write.
//  - Write out of range (addr_wr0 >= NUMBER_BRAM*DEPTH_SIZE): the write is dropped and no bank changes.
//  - Read: 1-cycle latency. Data_out0 after edge N equals mem[addr_rd0 sampled at edge N].
//    The read is always enabled; a new address is accepted every cycle.
//  - Output mux: the bank select is registered together with the read, so the mux picks the
//    registered bank data.
//  - Read out of range: Data_out0 = 0 on the following cycle.
//  - Read and write to the same address in the same cycle: read-first. Data_out0 returns the old
//    contents; the new value is visible from the next read.
//  - Reads and writes to different banks or offsets are fully independent.
//  - Reset (async, resetn_i=1): Data_out0 -> 0 immediately and the registered bank select -> 0.
//    Writes are suppressed while reset is asserted. RAM contents are NOT cleared.
//    Reset asserted during a write burst loses only the writes of the reset cycles.
//  - Initial RAM contents are undefined; simulation models initialise them to 0.
// STRUCTURE
//  - Sub-module bram_bank: a DEPTH_SIZE x DATA_WIDTH simple-dual-port RAM with we, waddr, wdata,
//    raddr and a registered rdata, coded for block-RAM inference. frame_buffer instantiates
//    NUMBER_BRAM of them in a generate loop and adds the decode, out-of-range and mux logic.
//  - Shared package: none required. Put BANK_SEL_W = $clog2(NUMBER_BRAM) and
//    OFFS_W = $clog2(DEPTH_SIZE) as localparams in the module.
// TESTING (defaults: 10 banks x 1024)
//  - Bank 0 edges: write 0 <- AAAA and 1023 <- 5555, then read 0 and 1023.
//    -> AAAA, then 5555, each one cycle after its address.
//  - Bank crossing: write 1024 <- BBBB and 2047 <- CCCC.
//    -> reads return BBBB and CCCC; addresses 1023 and 0 are unchanged.
//  - Last bank: write 9216 <- FFFF, read 9216 -> FFFF.
//    Write 10240 <- 1234 -> no bank is modified; a read of 10240 returns 0000.
//  - Back-to-back pipeline: read 0, 1023, 1024, 2047, 9216 on consecutive cycles.
//    -> AAAA, 5555, BBBB, CCCC, FFFF on consecutive cycles, each with 1-cycle lag.
//  - Collision and reset:
//    - Read and write 5 <- 0F0F in the same cycle -> old value; the next read gives 0F0F.
//    - Assert resetn_i=1 mid-stream -> Data_out0 = 0000 with no clock edge, and a write with wr0_i=1
//      during reset is ignored.
//    - Deassert reset -> address 0 still reads AAAA.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
// -----------------------------------------------------------------------------
// frame_buffer_pkg
// Purpose : Shared compile-time helpers for the banked frame store.
// Contents: is_pow2() -- lets the address decoder choose shift/mask slicing
//           over a constant divide/modulo when the bank depth allows it.
// -----------------------------------------------------------------------------
package frame_buffer_pkg;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/bram_bank.sv
// -----------------------------------------------------------------------------
// bram_bank
// Purpose : DEPTH x DATA_WIDTH simple-dual-port RAM, one write and one read port
//           on the same clock, registered read data (block-RAM inference).
//           A read and a write to the same word in one cycle return the old word.
// Ports   : clk_i    clock
//           we_i     write enable
//           waddr_i  write word address
//           wdata_i  write data
//           raddr_i  read word address (always enabled)
//           rdata_o  read data, valid one cycle after raddr_i
// -----------------------------------------------------------------------------
module bram_bank #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // No reset on the array or its output register so the tools can map
    // both into the RAM primitive.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer.sv
// -----------------------------------------------------------------------------
// frame_buffer
// Purpose : Banked simple-dual-port frame store. The flat pixel address space
//           is split over NUMBER_BRAM banks of DEPTH_SIZE words each. One
//           write port (pixel producer) and one read port (scan-out), both on
//           clk_i, read latency one cycle, read-first on collisions.
// Ports   : clk_i      clock
//           resetn_i   asynchronous reset, active HIGH despite the name
//           wr0_i      write enable
//           addr_wr0   flat write address
//           Data_in0   write data
//           addr_rd0   flat read address (read always enabled)
//           Data_out0  read data, one cycle after addr_rd0; 0 for an
//                      out-of-range address and while in reset
// -----------------------------------------------------------------------------
module frame_buffer
    import frame_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 16,
    parameter int NUMBER_BRAM = 10,
    parameter int DEPTH_SIZE  = 1024
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  wr0_i,
    input  logic [ADDR_WIDTH-1:0] addr_wr0,
    input  logic [DATA_WIDTH-1:0] Data_in0,
    input  logic [ADDR_WIDTH-1:0] addr_rd0,
    output logic [DATA_WIDTH-1:0] Data_out0
);

    localparam int BANK_SEL_W = (NUMBER_BRAM > 1) ? $clog2(NUMBER_BRAM) : 1;
    localparam int OFFS_W     = (DEPTH_SIZE  > 1) ? $clog2(DEPTH_SIZE)  : 1;
    // One extra bit so the capacity itself is representable even when it
    // equals 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] TOTAL_WORDS = (ADDR_WIDTH+1)'(NUMBER_BRAM * DEPTH_SIZE);

    logic [BANK_SEL_W-1:0] wr_bank;
    logic [OFFS_W-1:0]     wr_offs;
    logic [BANK_SEL_W-1:0] rd_bank;
    logic [OFFS_W-1:0]     rd_offs;
    logic                  wr_in_range;
    logic                  rd_in_range;

    logic [NUMBER_BRAM-1:0] bank_we;
    logic [DATA_WIDTH-1:0]  bank_rdata [NUMBER_BRAM];
    logic [DATA_WIDTH-1:0]  rd_mux;

    logic [BANK_SEL_W-1:0] bank_sel_q, bank_sel_d;
    logic                  rd_valid_q, rd_valid_d;

    // ---------------------------------------------------------------------
    // Address decode: bank = addr / DEPTH_SIZE, offset = addr % DEPTH_SIZE
    // ---------------------------------------------------------------------
    generate
        if (is_pow2(DEPTH_SIZE)) begin : g_decode_pow2
            assign wr_bank = BANK_SEL_W'(addr_wr0 >> OFFS_W);
            assign wr_offs = OFFS_W'(addr_wr0);
            assign rd_bank = BANK_SEL_W'(addr_rd0 >> OFFS_W);
            assign rd_offs = OFFS_W'(addr_rd0);
        end else begin : g_decode_div
            assign wr_bank = BANK_SEL_W'(addr_wr0 / ADDR_WIDTH'(DEPTH_SIZE));
            assign wr_offs = OFFS_W'(addr_wr0 % ADDR_WIDTH'(DEPTH_SIZE));
            assign rd_bank = BANK_SEL_W'(addr_rd0 / ADDR_WIDTH'(DEPTH_SIZE));
            assign rd_offs = OFFS_W'(addr_rd0 % ADDR_WIDTH'(DEPTH_SIZE));
        end
    endgenerate

    assign wr_in_range = ({1'b0, addr_wr0} < TOTAL_WORDS);
    assign rd_in_range = ({1'b0, addr_rd0} < TOTAL_WORDS);

    // ---------------------------------------------------------------------
    // Bank array. Only the addressed bank sees a write enable; the reset
    // term drops writes in cycles where reset is asserted.
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUMBER_BRAM; gi++) begin : g_bank
            assign bank_we[gi] = wr0_i && !resetn_i && wr_in_range
                               && (wr_bank == BANK_SEL_W'(gi));

            bram_bank #(
                .DEPTH      (DEPTH_SIZE),
                .DATA_WIDTH (DATA_WIDTH),
                .AW         (OFFS_W)
            ) u_bank (
                .clk_i   (clk_i),
                .we_i    (bank_we[gi]),
                .waddr_i (wr_offs),
                .wdata_i (Data_in0),
                .raddr_i (rd_offs),
                .rdata_o (bank_rdata[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Read-side select, registered alongside the bank read so it lines up
    // with bank_rdata. rd_valid_q also forces the output to zero for an
    // out-of-range read and, through its async reset, immediately on reset.
    // ---------------------------------------------------------------------
    assign bank_sel_d = rd_bank;
    assign rd_valid_d = rd_in_range;

    always_ff @(posedge clk_i or posedge resetn_i) begin
        if (resetn_i) begin
            bank_sel_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            bank_sel_q <= bank_sel_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUMBER_BRAM; i++) begin
            if (bank_sel_q == BANK_SEL_W'(i)) begin
                rd_mux = bank_rdata[i];
            end
        end
    end

    assign Data_out0 = rd_valid_q ? rd_mux : '0;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer (10 banks x 1024 words, 16-bit data).
module tb_frame_buffer;

    logic        clk_i;
    logic        resetn_i;
    logic        wr0_i;
    logic [31:0] addr_wr0;
    logic [15:0] Data_in0;
    logic [31:0] addr_rd0;
    logic [15:0] Data_out0;

    int checks;
    int failures;

    frame_buffer #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (16),
        .NUMBER_BRAM (10),
        .DEPTH_SIZE  (1024)
    ) dut (
        .clk_i     (clk_i),
        .resetn_i  (resetn_i),
        .wr0_i     (wr0_i),
        .addr_wr0  (addr_wr0),
        .Data_in0  (Data_in0),
        .addr_rd0  (addr_rd0),
        .Data_out0 (Data_out0)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [31:0] wa, input logic [15:0] wd,
                         input logic [31:0] ra);
        wr0_i    = wr;
        addr_wr0 = wa;
        Data_in0 = wd;
        addr_rd0 = ra;
    endtask

    // Read-only pipeline vectors: address presented, value expected next cycle.
    logic [31:0] pipe_addr [5];
    logic [15:0] pipe_data [5];

    initial begin
        checks   = 0;
        failures = 0;
        pipe_addr = '{32'd0, 32'd1023, 32'd1024, 32'd2047, 32'd9216};
        pipe_data = '{16'hAAAA, 16'h5555, 16'hBBBB, 16'hCCCC, 16'hFFFF};

        resetn_i = 1'b1;
        drive(1'b0, 32'd0, 16'h0000, 32'd0);
        tick();
        tick();
        chk("reset_out", Data_out0, 16'h0000);
        resetn_i = 1'b0;

        // Bank 0 edges, then bank crossing and last bank, with reads trailing.
        drive(1'b1, 32'd0,     16'hAAAA, 32'd10240); tick();
        chk("rd_oor_first", Data_out0, 16'h0000);
        drive(1'b1, 32'd1023,  16'h5555, 32'd0);     tick();
        chk("rd_0", Data_out0, 16'hAAAA);
        drive(1'b1, 32'd1024,  16'hBBBB, 32'd1023);  tick();
        chk("rd_1023", Data_out0, 16'h5555);
        drive(1'b1, 32'd2047,  16'hCCCC, 32'd1024);  tick();
        chk("rd_1024", Data_out0, 16'hBBBB);
        drive(1'b1, 32'd9216,  16'hFFFF, 32'd2047);  tick();
        chk("rd_2047", Data_out0, 16'hCCCC);
        drive(1'b1, 32'd10240, 16'h1234, 32'd9216);  tick();
        chk("rd_9216", Data_out0, 16'hFFFF);
        drive(1'b1, 32'd10239, 16'h7777, 32'd10240); tick();
        chk("rd_10240_oor", Data_out0, 16'h0000);
        drive(1'b0, 32'd0,     16'h0000, 32'd10239); tick();
        chk("rd_10239_last", Data_out0, 16'h7777);

        // Back-to-back reads; also confirms 0 and 1023 survived the other writes
        // and the dropped write to 10240 did not alias onto bank 0.
        for (int i = 0; i < 5; i++) begin
            addr_rd0 = pipe_addr[i];
            tick();
            chk($sformatf("pipe_%0d", pipe_addr[i]), Data_out0, pipe_data[i]);
        end

        // Read-first collision.
        drive(1'b1, 32'd5, 16'h1111, 32'd5); tick();
        drive(1'b1, 32'd5, 16'h0F0F, 32'd5); tick();
        chk("collide_old", Data_out0, 16'h1111);
        drive(1'b0, 32'd5, 16'h0000, 32'd5); tick();
        chk("collide_new", Data_out0, 16'h0F0F);

        // Async reset mid-stream, write during reset dropped.
        drive(1'b0, 32'd0, 16'h0000, 32'd0); tick();
        chk("pre_reset_rd0", Data_out0, 16'hAAAA);
        #2;
        resetn_i = 1'b1;
        #1;
        chk("async_reset_out", Data_out0, 16'h0000);
        drive(1'b1, 32'd0, 16'hDEAD, 32'd0); tick();
        chk("in_reset_out", Data_out0, 16'h0000);
        wr0_i    = 1'b0;
        resetn_i = 1'b0;
        tick();
        chk("post_reset_rd0", Data_out0, 16'hAAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
